// File: rtl/vram_line_fetch.sv
// VRAM line prefetcher: fills the back half of a ping-pong line buffer
// over a req/ack memory port while the video stage reads the front half.
module vram_line_fetch #(
  parameter int WORDS = 32,
  parameter int CW    = 5,
  parameter int LW    = 9,
  parameter int AW    = 14
) (
  input  logic          clk_pix,
  input  logic          rst_n,
  input  logic          line_start,
  input  logic [LW-1:0] next_line,
  input  logic [CW-1:0] vid_addr,
  output logic [15:0]   vid_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [15:0]   mem_din,
  output logic          busy,
  output logic          underrun,
  input  logic          clr_underrun
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t        state;
  logic          sel;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line_reg;

  logic [15:0] mem_buf [0:1][0:WORDS-1];

  logic          ack_ok;
  logic          last;
  logic          abort;
  logic [CW-1:0] cnt_nxt;

  assign ack_ok  = (state == FETCH) && mem_ack;
  assign last    = (cnt == CW'(WORDS - 1));
  assign abort   = (state == FETCH) && line_start && !(mem_ack && last);
  assign cnt_nxt = cnt + CW'(1);

  // Write targets the pre-swap back buffer, even on a restart cycle
  always_ff @(posedge clk_pix) begin
    if (ack_ok)
      mem_buf[~sel][cnt] <= mem_din;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      cnt      <= '0;
      line_reg <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      vid_data <= '0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vid_data <= mem_buf[sel][vid_addr];

      if (abort)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;

      if (line_start) begin
        sel      <= ~sel;
        line_reg <= next_line;
        cnt      <= '0;
        mem_addr <= {next_line, {CW{1'b0}}};
        mem_rd   <= 1'b1;
        busy     <= 1'b1;
        state    <= FETCH;
      end else if (ack_ok) begin
        cnt      <= cnt_nxt;
        mem_addr <= {line_reg, cnt_nxt};
        if (last) begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_line_fetch.sv
// Scoreboard bench for vram_line_fetch: stimulus queues expected read data
// and memory addresses; a negedge monitor pops and compares.
module tb_vram_line_fetch;

  logic        clk_pix = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  next_line = '0;
  logic [4:0]  vid_addr = '0;
  logic [15:0] vid_data;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_din = '0;
  logic        busy;
  logic        underrun;
  logic        clr_underrun = 1'b0;

  vram_line_fetch dut (
    .clk_pix      (clk_pix),
    .rst_n        (rst_n),
    .line_start   (line_start),
    .next_line    (next_line),
    .vid_addr     (vid_addr),
    .vid_data     (vid_data),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ack      (mem_ack),
    .mem_din      (mem_din),
    .busy         (busy),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_q [$];
  logic [13:0] addr_q [$];
  logic        rd_en = 1'b0;
  logic        rd_vld = 1'b0;

  always @(posedge clk_pix) rd_vld <= rd_en;

  always @(negedge clk_pix) begin
    logic [15:0] ed;
    logic [13:0] ea;
    if (rd_vld) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_q underflow vid_data=%h", vid_data);
      end else begin
        ed = rd_q.pop_front();
        if (vid_data !== ed) begin
          errors++;
          $display("FAIL vid_data got %h want %h", vid_data, ed);
        end
      end
    end
    if (rst_n && mem_ack && mem_rd) begin
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL addr_q underflow mem_addr=%h", mem_addr);
      end else begin
        ea = addr_q.pop_front();
        if (mem_addr !== ea) begin
          errors++;
          $display("FAIL mem_addr got %h want %h", mem_addr, ea);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic ack(input logic [13:0] a, input logic [15:0] d);
    mem_ack = 1'b1;
    mem_din = d;
    addr_q.push_back(a);
    step();
    mem_ack = 1'b0;
  endtask

  task automatic start(input logic [8:0] nl);
    next_line  = nl;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] e);
    vid_addr = a;
    rd_en    = 1'b1;
    rd_q.push_back(e);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst mem_rd", 16'(mem_rd), 16'h0);
    chk("rst busy", 16'(busy), 16'h0);
    chk("rst underrun", 16'(underrun), 16'h0);
    chk("rst vid_data", vid_data, 16'h0);
    chk("rst mem_addr", 16'(mem_addr), 16'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // full fill of line 0x100, one ack per cycle
    start(9'h100);
    chk("fill1 start addr", 16'(mem_addr), 16'h2000);
    chk("fill1 busy", 16'(busy), 16'h1);
    for (int i = 0; i < 32; i++)
      ack(14'h2000 + 14'(i), 16'hA000 + 16'(i));
    chk("fill1 busy fall", 16'(busy), 16'h0);
    chk("fill1 mem_rd fall", 16'(mem_rd), 16'h0);
    chk("fill1 underrun", 16'(underrun), 16'h0);

    // swap and read back, then slow fetch aborted by line_start
    start(9'h0F0);
    chk("fill2 start addr", 16'(mem_addr), 16'h1E00);
    rd(5'd7, 16'hA007);
    rd(5'd31, 16'hA01F);
    for (int i = 0; i < 10; i++) begin
      ack(14'h1E00 + 14'(i), 16'hB000 + 16'(i));
      step();
      step();
    end
    chk("pre-abort underrun", 16'(underrun), 16'h0);
    start(9'h005);
    chk("abort underrun", 16'(underrun), 16'h1);
    chk("abort restart addr", 16'(mem_addr), 16'h00A0);
    chk("abort mem_rd", 16'(mem_rd), 16'h1);
    chk("abort busy", 16'(busy), 16'h1);
    rd(5'd3, 16'hB003);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("clr underrun", 16'(underrun), 16'h0);

    // line_start together with the final ack
    for (int i = 0; i < 31; i++)
      ack(14'h00A0 + 14'(i), 16'hC000 + 16'(i));
    next_line  = 9'h0C0;
    line_start = 1'b1;
    ack(14'h00BF, 16'hC01F);
    line_start = 1'b0;
    chk("final+start underrun", 16'(underrun), 16'h0);
    chk("final+start addr", 16'(mem_addr), 16'h1800);
    chk("final+start mem_rd", 16'(mem_rd), 16'h1);
    rd(5'd31, 16'hC01F);
    rd(5'd0, 16'hC000);
    for (int i = 0; i < 32; i++)
      ack(14'h1800 + 14'(i), 16'hD000 + 16'(i));
    chk("fill4 busy fall", 16'(busy), 16'h0);

    // spurious ack while idle must not write or advance
    mem_ack = 1'b1;
    mem_din = 16'hFFFF;
    step();
    mem_ack = 1'b0;
    chk("spurious mem_addr", 16'(mem_addr), 16'h1800);
    chk("spurious mem_rd", 16'(mem_rd), 16'h0);
    start(9'h0C1);
    chk("fill5 start addr", 16'(mem_addr), 16'h1820);
    rd(5'd0, 16'hD000);
    rd(5'd5, 16'hD005);

    // async reset mid-fetch
    for (int i = 0; i < 12; i++)
      ack(14'h1820 + 14'(i), 16'hE000 + 16'(i));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst mem_rd", 16'(mem_rd), 16'h0);
    chk("midrst busy", 16'(busy), 16'h0);
    chk("midrst vid_data", vid_data, 16'h0);
    chk("midrst underrun", 16'(underrun), 16'h0);
    chk("midrst mem_addr", 16'(mem_addr), 16'h0);
    step();
    rst_n = 1'b1;
    step();
    start(9'h1FF);
    chk("postrst addr", 16'(mem_addr), 16'h3FE0);
    chk("postrst mem_rd", 16'(mem_rd), 16'h1);
    ack(14'h3FE0, 16'h1234);
    ack(14'h3FE1, 16'h1235);
    rd(5'd2, 16'hD002);
    step();
    step();

    checks++;
    if (rd_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL queues rd=%0d addr=%0d want 0", rd_q.size(),
               addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
